// File: rtl/alu_seq.sv
// alu_seq: sequential execute stage. Takes one decoded operation per
// transaction and returns write-back register IDs, write enables, results and
// a halt flag. ADD/OR/AND/MOV/RET/NOP complete in one cycle. MUL is an
// iterative unsigned shift-add multiplier that produces a 2*WIDTH-bit product,
// split across two destination registers.
//
// Build option:
//   ALU_RADIX4_MUL_EN  - when defined, the multiplier retires two multiplier
//                        bits per cycle (WIDTH/2 iterations) instead of one.
//                        The results are the same; only the latency changes.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operation handshake
//   in_op               0 ADD, 1 OR, 2 AND, 3 MOV, 4 MUL, 5 RET, 6-7 NOP
//   in_dst              destination register for ADD/OR/AND/MOV
//   in_a, in_b          operands (in_b already resolved from register or immediate)
//   out_valid/out_ready result handshake
//   out_lo_wen/id/lo    low-result write port
//   out_hi_wen/id/hi    high-result write port (MUL only)
//   out_halt            the transaction was RET
//   dbg_state           current FSM state (0 IDLE, 1 MUL, 2 DONE)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holds valid and its payload until that transfer
// occurs. Outputs stay stable while out_valid && !out_ready. in_ready does
// not depend on in_valid. In DONE, in_ready follows out_ready, so a result
// can be popped and a new operation accepted on the same edge.

module alu_seq #(
    parameter int WIDTH     = 64,
    parameter int REG_ID_W  = 4,
    parameter int MUL_LO_ID = 0,
    parameter int MUL_HI_ID = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_op,
    input  logic [REG_ID_W-1:0] in_dst,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_lo_wen,
    output logic [REG_ID_W-1:0] out_lo_id,
    output logic [WIDTH-1:0]    out_lo,
    output logic                out_hi_wen,
    output logic [REG_ID_W-1:0] out_hi_id,
    output logic [WIDTH-1:0]    out_hi,
    output logic                out_halt,
    output logic [1:0]          dbg_state
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_MOV = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;
    localparam logic [2:0] OP_RET = 3'd5;

`ifdef ALU_RADIX4_MUL_EN
    localparam int SHIFT = 2;
`else
    localparam int SHIFT = 1;
`endif
    localparam int ITERS = WIDTH / SHIFT;
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             accept;
    logic             last_iter;
    logic [CNT_W-1:0] cnt_q;
    logic [PW-1:0]    acc_q;     // running partial product
    logic [PW-1:0]    mcand_q;   // multiplicand, shifted left each iteration
    logic [WIDTH-1:0] mplier_q;  // multiplier, shifted right each iteration
    logic [PW-1:0]    step_add;
    logic [PW-1:0]    acc_next;

    logic [WIDTH-1:0] alu_lo;
    logic             alu_lo_wen;
    logic             alu_halt;

    assign dbg_state = state_q;
    assign last_iter = (cnt_q == CNT_W'(ITERS - 1));
    assign acc_next  = acc_q + step_add;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_d = (in_op == OP_MUL) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                accept    = in_valid && out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        state_d = (in_op == OP_MUL) ? S_MUL : S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Single-cycle operations
    always_comb begin
        alu_lo     = '0;
        alu_lo_wen = 1'b0;
        alu_halt   = 1'b0;
        case (in_op)
            OP_ADD: begin
                alu_lo     = in_a + in_b;
                alu_lo_wen = 1'b1;
            end
            OP_OR: begin
                alu_lo     = in_a | in_b;
                alu_lo_wen = 1'b1;
            end
            OP_AND: begin
                alu_lo     = in_a & in_b;
                alu_lo_wen = 1'b1;
            end
            OP_MOV: begin
                alu_lo     = in_b;
                alu_lo_wen = 1'b1;
            end
            OP_RET: alu_halt = 1'b1;
            default: ;
        endcase
    end

    // Partial-product selection for one iteration
`ifdef ALU_RADIX4_MUL_EN
    always_comb begin
        step_add = '0;
        case (mplier_q[1:0])
            2'd1:    step_add = mcand_q;
            2'd2:    step_add = mcand_q << 1;
            2'd3:    step_add = mcand_q + (mcand_q << 1);
            default: step_add = '0;
        endcase
    end
`else
    always_comb begin
        step_add = '0;
        if (mplier_q[0]) begin
            step_add = mcand_q;
        end
    end
`endif

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            out_lo     <= '0;
            out_lo_id  <= '0;
            out_lo_wen <= 1'b0;
            out_hi     <= '0;
            out_hi_id  <= '0;
            out_hi_wen <= 1'b0;
            out_halt   <= 1'b0;
        end else if (accept) begin
            if (in_op == OP_MUL) begin
                cnt_q    <= '0;
                acc_q    <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, in_a};
                mplier_q <= in_b;
            end else begin
                out_lo     <= alu_lo;
                out_lo_id  <= alu_lo_wen ? in_dst : '0;
                out_lo_wen <= alu_lo_wen;
                out_hi     <= '0;
                out_hi_id  <= '0;
                out_hi_wen <= 1'b0;
                out_halt   <= alu_halt;
            end
        end else if (state_q == S_MUL) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << SHIFT;
            mplier_q <= mplier_q >> SHIFT;
            cnt_q    <= cnt_q + CNT_W'(1);
            // The last iteration writes the finished product straight to the
            // outputs so DONE is entered on the same edge.
            if (last_iter) begin
                cnt_q      <= '0;
                out_lo     <= acc_next[WIDTH-1:0];
                out_lo_id  <= REG_ID_W'(MUL_LO_ID);
                out_lo_wen <= 1'b1;
                out_hi     <= acc_next[PW-1:WIDTH];
                out_hi_id  <= REG_ID_W'(MUL_HI_ID);
                out_hi_wen <= 1'b1;
                out_halt   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int WIDTH = 64;
    localparam int RID   = 4;
    localparam int EXP_W = 3 + 2 * RID + 2 * WIDTH;
    localparam int CHK_W = 160;
`ifdef ALU_RADIX4_MUL_EN
    localparam int MUL_LAT = WIDTH / 2 + 1;
`else
    localparam int MUL_LAT = WIDTH + 1;
`endif

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [RID-1:0]   in_dst;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic             out_lo_wen;
    logic [RID-1:0]   out_lo_id;
    logic [WIDTH-1:0] out_lo;
    logic             out_hi_wen;
    logic [RID-1:0]   out_hi_id;
    logic [WIDTH-1:0] out_hi;
    logic             out_halt;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mask_q[$];

    alu_seq #(
        .WIDTH(WIDTH), .REG_ID_W(RID), .MUL_LO_ID(0), .MUL_HI_ID(2)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_dst(in_dst), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lo_wen(out_lo_wen), .out_lo_id(out_lo_id), .out_lo(out_lo),
        .out_hi_wen(out_hi_wen), .out_hi_id(out_hi_id), .out_hi(out_hi),
        .out_halt(out_halt), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [CHK_W-1:0] act, input logic [CHK_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model. Packing: {halt, lo_wen, hi_wen, lo_id, hi_id, lo, hi}.
    // Mask covers only the fields that are defined for the operation.
    function automatic void model(input logic [2:0] op, input logic [RID-1:0] dst,
                                  input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  output logic [EXP_W-1:0] e, output logic [EXP_W-1:0] m);
        logic             halt, lw, hw;
        logic [RID-1:0]   lid, hid;
        logic [WIDTH-1:0] lo, hi;
        logic [2*WIDTH-1:0] p;
        logic             m_lo, m_hi, m_hid;
        halt = 0; lw = 0; hw = 0; lid = 0; hid = 0; lo = 0; hi = 0;
        m_lo = 0; m_hi = 0; m_hid = 0;
        case (op)
            3'd0: begin lo = a + b; lw = 1; lid = dst; m_lo = 1; m_hi = 1; end
            3'd1: begin lo = a | b; lw = 1; lid = dst; m_lo = 1; m_hi = 1; end
            3'd2: begin lo = a & b; lw = 1; lid = dst; m_lo = 1; m_hi = 1; end
            3'd3: begin lo = b;     lw = 1; lid = dst; m_lo = 1; m_hi = 1; end
            3'd4: begin
                p  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
                lo = p[WIDTH-1:0]; hi = p[2*WIDTH-1:WIDTH];
                lw = 1; hw = 1; lid = 4'd0; hid = 4'd2;
                m_lo = 1; m_hi = 1; m_hid = 1;
            end
            3'd5: halt = 1;
            default: ;
        endcase
        e = {halt, lw, hw, lid, hid, lo, hi};
        m = {3'b111, {RID{m_lo}}, {RID{m_hid}}, {WIDTH{m_lo}}, {WIDTH{m_hi}}};
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] e, m, act;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", CHK_W'(1), CHK_W'(0));
            end else begin
                e = exp_q.pop_front();
                m = mask_q.pop_front();
                act = {out_halt, out_lo_wen, out_hi_wen, out_lo_id, out_hi_id, out_lo, out_hi};
                check("result", CHK_W'(act & m), CHK_W'(e & m));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    // Call just after a rising edge. Returns just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [RID-1:0] dst,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output int waits);
        logic [EXP_W-1:0] e, m;
        in_valid = 1'b1; in_op = op; in_dst = dst; in_a = a; in_b = b;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 300) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            check("accept_timeout", CHK_W'(0), CHK_W'(1));
        end else begin
            model(op, dst, a, b, e, m);
            exp_q.push_back(e);
            mask_q.push_back(m);
        end
        @(posedge clk); #1;
        // Scramble the inputs: they must only matter on the accept edge.
        in_valid = 1'b0;
        in_op    = 3'($urandom_range(0, 7));
        in_dst   = RID'($urandom_range(0, 15));
        in_a     = {$urandom(), $urandom()};
        in_b     = {$urandom(), $urandom()};
    endtask

    // Counts falling edges after an accept until out_valid is seen.
    task automatic wait_valid(output int k, output bit rdy_seen);
        k = 0;
        rdy_seen = 0;
        do begin
            @(negedge clk);
            k++;
            if (!out_valid && in_ready) rdy_seen = 1;
        end while (!out_valid && k < 300);
    endtask

    task automatic check_idle(input string tag);
        check(tag, CHK_W'({out_valid, in_ready, out_halt, out_lo_wen, out_hi_wen,
                           out_lo_id, out_hi_id, out_lo, out_hi, dbg_state}),
              CHK_W'({1'b0, 1'b1, 3'b000, 8'h00, {2*WIDTH{1'b0}}, 2'd0}));
    endtask

    // ---------------- test sequence ----------------
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    initial begin
        int w, k, drain;
        bit r;
        reset = 1'b1; in_valid = 1'b0; in_op = '0; in_dst = '0;
        in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset_state");
        step();
        reset = 1'b0;

        // ADD with carry out of the top bit
        send(3'd0, 4'd5, ONES, 64'd1, w);
        wait_valid(k, r);
        check("add_latency", CHK_W'(k), CHK_W'(1));
        step();

        // MUL of all-ones operands
        send(3'd4, 4'd0, ONES, ONES, w);
        wait_valid(k, r);
        check("mul_latency", CHK_W'(k), CHK_W'(MUL_LAT));
        check("mul_in_ready_low", CHK_W'(r), CHK_W'(0));
        step();

        // OR / AND / MOV streamed back-to-back
        send(3'd1, 4'd1, 64'hF0, 64'h3C, w);
        check("stream_or_wait", CHK_W'(w), CHK_W'(0));
        send(3'd2, 4'd6, 64'hF0, 64'h3C, w);
        check("stream_and_wait", CHK_W'(w), CHK_W'(0));
        send(3'd3, 4'd7, 64'hF0, 64'h3C, w);
        check("stream_mov_wait", CHK_W'(w), CHK_W'(0));
        wait_valid(k, r);
        check("stream_mov_latency", CHK_W'(k), CHK_W'(1));
        step();

        // Backpressure: hold the result in DONE for 10 cycles
        out_ready = 1'b0;
        send(3'd0, 4'd3, 64'd7, 64'd8, w);
        wait_valid(k, r);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_stable", CHK_W'({out_valid, in_ready, out_lo_wen, out_lo_id, out_lo}),
                  CHK_W'({1'b1, 1'b0, 1'b1, 4'd3, 64'd15}));
        end
        step();
        out_ready = 1'b1;
        send(3'd3, 4'd9, 64'd0, 64'hAB, w);
        check("pop_and_accept_same_cycle", CHK_W'(w), CHK_W'(0));
        wait_valid(k, r);
        check("after_pop_latency", CHK_W'(k), CHK_W'(1));
        step();

        // Reset in the middle of a MUL
        send(3'd4, 4'd0, 64'd123456789, 64'd987654321, w);
        repeat (19) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        mask_q.delete();
        @(negedge clk);
        check_idle("mid_mul_reset_state");
        step();
        send(3'd0, 4'd4, 64'd2, 64'd3, w);
        wait_valid(k, r);
        check("post_reset_add_latency", CHK_W'(k), CHK_W'(1));
        step();

        // RET then NOP
        send(3'd5, 4'd1, 64'd1, 64'd2, w);
        wait_valid(k, r);
        step();
        send(3'd6, 4'd1, 64'd1, 64'd2, w);
        wait_valid(k, r);
        step();

        // Random mix, including MUL and both NOP encodings
        for (int i = 0; i < 24; i++) begin
            send(3'($urandom_range(0, 7)), RID'($urandom_range(0, 15)),
                 {$urandom(), $urandom()}, {$urandom(), $urandom()}, w);
        end

        drain = 0;
        while (exp_q.size() != 0 && drain < 500) begin
            @(negedge clk);
            drain++;
        end
        check("scoreboard_empty", CHK_W'(exp_q.size()), CHK_W'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
